// File: rtl/aes_pkg.sv
// Shared constants, state encoding and round-constant lookup for the AES-128 key schedule.
package aes_pkg;

  localparam int NR     = 10;
  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  typedef enum logic {IDLE, EXPAND} state_t;

  // Entry r-1 holds rcon for round r; round 1 sits in the low byte.
  localparam logic [8*NR-1:0] RCON_TBL = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    int i;
    i = int'(r) - 1;
    if (i >= 0 && i < NR) return RCON_TBL[i*8 +: 8];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes128_key_round_step.sv
// One AES-128 key-expansion round: derives rk[n] from rk[n-1] and rcon(n).
module aes128_key_round_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] rk_prev,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] rk_next
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot, sub, t;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0  = rk_prev[127:96];
  assign w1  = rk_prev[95:64];
  assign w2  = rk_prev[63:32];
  assign w3  = rk_prev[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sub_box u_sbox (
      .din  (rot[b*8 +: 8]),
      .dout (sub[b*8 +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/sub_box.sv
// AES forward S-box for one byte: multiplicative inverse in GF(2^8) followed by the affine map.
module sub_box (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv  = gf_inv(din);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry file with a registered read port.
module aes128_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR_P  = NR,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              keys_valid,
  output logic              done,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [KEY_W-1:0]  rd_key,
  output logic              rd_ok
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rcnt;
  logic [KEY_W-1:0] rk [0:NR_P];
  logic [KEY_W-1:0] rk_prev, rk_next, rd_sel;
  logic             accept, step, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        step = 1'b1;
        if (rcnt == IDX_W'(NR_P)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded muxes keep every file access inside 0..NR even for stray index values.
  always_comb begin
    rk_prev = '0;
    for (int i = 1; i <= NR_P; i++)
      if (rcnt == IDX_W'(i)) rk_prev = rk[i-1];
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NR_P; i++)
      if (rd_idx == IDX_W'(i)) rd_sel = rk[i];
  end

  aes128_key_round_step u_step (
    .rk_prev (rk_prev),
    .rcon    (rcon_of(4'(rcnt))),
    .rk_next (rk_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt       <= '0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      rd_key     <= '0;
      rd_ok      <= 1'b0;
      for (int i = 0; i <= NR_P; i++) rk[i] <= '0;
    end else begin
      done <= last;
      if (accept) begin
        rk[0]      <= key_in;
        rcnt       <= IDX_W'(1);
        keys_valid <= 1'b0;
      end
      if (step) begin
        for (int i = 1; i <= NR_P; i++)
          if (rcnt == IDX_W'(i)) rk[i] <= rk_next;
        rcnt <= last ? '0 : rcnt + 1'b1;
        if (last) keys_valid <= 1'b1;
      end
      // Read sees pre-edge file and flags; no write-to-read bypass.
      rd_key <= rd_sel;
      rd_ok  <= (rd_idx <= IDX_W'(NR_P)) && (keys_valid || (busy && (rd_idx < rcnt)));
    end
  end

  a_rcnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EXPAND) |-> (rcnt >= IDX_W'(1) && rcnt <= IDX_W'(NR_P)));

  a_done_once: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Scoreboard bench for aes128_key_sched_ctrl using FIPS-197 and all-zero key vectors.
module tb_aes128_key_sched_ctrl;

  localparam logic [127:0] F0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z0  = 128'h0;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         busy, keys_valid, done;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
  logic         rd_ok;

  aes128_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_ok      (rd_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         chk;
    logic [127:0] key;
    logic         ok;
    logic [3:0]   idx;
  } rd_exp_t;

  int      n_vec = 0;
  int      n_err = 0;
  int      cyc = 0;
  rd_exp_t rd_q[$];
  int      done_q[$];
  logic    rd_req = 1'b0;
  logic    rd_pend = 1'b0;
  logic    done_prev = 1'b0;
  rd_exp_t mon_e;
  int      mon_c;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  // Monitor: pops a read expectation one cycle after each issued read, and a done expectation per pulse.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_unexpected: got read response expected none");
      end else begin
        mon_e = rd_q.pop_front();
        check($sformatf("rd_ok[%0d]", mon_e.idx), 128'(rd_ok), 128'(mon_e.ok));
        if (mon_e.chk) check($sformatf("rd_key[%0d]", mon_e.idx), rd_key, mon_e.key);
      end
    end
    if (done_prev) check("done_width", 128'(done), 128'(0));
    if (done) begin
      if (done_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        mon_c = done_q.pop_front();
        check("done_cycle", 128'(cyc), 128'(mon_c));
      end
    end
    done_prev = done;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_read(input logic [3:0] idx, input logic chk, input logic [127:0] k, input logic ok);
    rd_exp_t e;
    e.chk = chk; e.key = k; e.ok = ok; e.idx = idx;
    rd_q.push_back(e);
    rd_idx = idx;
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic start_key(input logic [127:0] k, input bit exp_done, output int e0);
    int w;
    w = 0;
    while (!key_ready && w < 50) begin
      tick(1);
      w++;
    end
    check("key_ready_wait", 128'(key_ready), 128'(1));
    key_valid = 1'b1;
    key_in    = k;
    tick(1);
    key_valid = 1'b0;
    key_in    = ~k;
    e0 = cyc;
    if (exp_done) done_q.push_back(e0 + 10);
    check("accept_busy", 128'(busy), 128'(1));
    check("accept_key_ready", 128'(key_ready), 128'(0));
    check("accept_keys_valid", 128'(keys_valid), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int      e0, e1;
    logic [127:0] kk [0:2];
    logic [127:0] kr [0:2];

    #12;
    check("rst_key_ready", 128'(key_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_valid", 128'(keys_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_rd_key", rd_key, 128'(0));
    check("rst_rd_ok", 128'(rd_ok), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // FIPS-197 key with reads interleaved during expansion, then a full index sweep.
    start_key(F0, 1, e0);
    for (int j = 0; j < 10; j++) begin
      if (j % 2 == 0) issue_read(4'(j ^ 1), 1'b0, '0, 1'b0);
      else            issue_read(4'(j - 1), (j == 1), F0, 1'b1);
    end
    check("f_keys_valid", 128'(keys_valid), 128'(1));
    check("f_key_ready", 128'(key_ready), 128'(1));
    check("f_busy", 128'(busy), 128'(0));
    for (int j = 0; j < 16; j++) begin
      if (j == 0)       issue_read(4'(j), 1'b1, F0, 1'b1);
      else if (j == 1)  issue_read(4'(j), 1'b1, F1, 1'b1);
      else if (j == 10) issue_read(4'(j), 1'b1, F10, 1'b1);
      else if (j > 10)  issue_read(4'(j), 1'b1, '0, 1'b0);
      else              issue_read(4'(j), 1'b0, '0, 1'b1);
    end

    // All-zero key.
    start_key(Z0, 1, e0);
    tick(10);
    issue_read(4'd0, 1'b1, Z0, 1'b1);
    issue_read(4'd1, 1'b1, Z1, 1'b1);
    issue_read(4'd2, 1'b1, Z2, 1'b1);
    issue_read(4'd10, 1'b1, Z10, 1'b1);

    // key_valid held high across expansion with a different key presented.
    key_valid = 1'b1;
    key_in    = F0;
    tick(1);
    e0 = cyc;
    done_q.push_back(e0 + 10);
    key_in = Z0;
    check("hold_ready_e0", 128'(key_ready), 128'(0));
    for (int j = 1; j <= 9; j++) begin
      issue_read(4'(11 + j % 5), 1'b1, '0, 1'b0);
      check("hold_ready", 128'(key_ready), 128'(0));
    end
    tick(1);
    check("hold_ready_idle", 128'(key_ready), 128'(1));
    check("hold_keys_valid", 128'(keys_valid), 128'(1));
    issue_read(4'd10, 1'b1, F10, 1'b1);
    e1 = cyc;
    done_q.push_back(e1 + 10);
    key_valid = 1'b0;
    check("hold_reaccept_busy", 128'(busy), 128'(1));
    check("hold_reaccept_kv", 128'(keys_valid), 128'(0));
    issue_read(4'd10, 1'b0, '0, 1'b0);
    tick(9);
    issue_read(4'd10, 1'b1, Z10, 1'b1);

    // Reset in the middle of an expansion.
    start_key(F0, 0, e0);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_key_ready", 128'(key_ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_keys_valid", 128'(keys_valid), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    check("mid_rst_rd_key", rd_key, 128'(0));
    check("mid_rst_rd_ok", 128'(rd_ok), 128'(0));
    tick(3);
    rst_n = 1'b1;
    tick(1);
    issue_read(4'd0, 1'b1, '0, 1'b0);
    start_key(Z0, 1, e0);
    tick(10);
    issue_read(4'd1, 1'b1, Z1, 1'b1);
    issue_read(4'd10, 1'b1, Z10, 1'b1);

    // Back-to-back keys with key_valid tied high; key_in switched at each done.
    kk[0] = F0;  kk[1] = Z0;  kk[2] = F0;
    kr[0] = F10; kr[1] = Z10; kr[2] = F10;
    key_valid = 1'b1;
    key_in    = kk[0];
    tick(1);
    e0 = cyc;
    for (int k = 0; k < 3; k++) begin
      done_q.push_back(e0 + 10);
      tick(10);
      check("b2b_done_seen", 128'(done), 128'(1));
      if (k < 2) key_in = kk[k+1];
      else       key_valid = 1'b0;
      issue_read(4'd10, 1'b1, kr[k], 1'b1);
      if (k < 2) begin
        check("b2b_busy", 128'(busy), 128'(1));
        check("b2b_keys_valid", 128'(keys_valid), 128'(0));
      end
      e0 = cyc;
    end

    tick(5);
    check("done_q_drained", 128'(done_q.size()), 128'(0));
    check("rd_q_drained", 128'(rd_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
